// File: rtl/jstk_pkg.sv
// Shared definitions for the JSTK2 poller.
// FSM encoding, frame length and JSTK2 command codes.
package jstk_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_HOLD
    } state_t;

    localparam int         FRAME_LEN   = 5;
    localparam logic [7:0] CMD_SET_LED = 8'h84;
    localparam logic [7:0] CMD_POLL    = 8'h00;

    // Byte idx of a set-LED frame: cmd, R, G, B, pad.
    function automatic logic [7:0] led_byte(
        input logic [2:0]  idx,
        input logic [23:0] rgb
    );
        logic [7:0] b;
        b = CMD_POLL;
        unique case (idx)
            3'd0:    b = CMD_SET_LED;
            3'd1:    b = rgb[23:16];
            3'd2:    b = rgb[15:8];
            3'd3:    b = rgb[7:0];
            default: b = CMD_POLL;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jstk_poller_spi_master.sv
// Byte-wide SPI master, one byte per TX DV pulse.
// MOSI shifts on the trailing edge, MISO samples on the leading edge.
module SPI_Master #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       i_Rst_L,
    input  logic       i_Clk,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
);

    localparam logic CPOL = (SPI_MODE >= 2);
    localparam int   HW   = (CLKS_PER_HALF_BIT > 1) ?
                            $clog2(CLKS_PER_HALF_BIT) : 1;

    logic          busy;
    logic          sck;
    logic [HW-1:0] half_cnt;
    logic [4:0]    edges;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;

    assign o_TX_Ready = ~busy;
    assign o_RX_Byte  = rx_sr;
    assign o_SPI_MOSI = tx_sr[7];
    assign o_SPI_Clk  = sck ^ CPOL;

    // Generate 16 SCK edges per byte, shifting data on each.
    always_ff @(posedge i_Clk) begin
        o_RX_DV <= 1'b0;
        if (!i_Rst_L) begin
            busy     <= 1'b0;
            sck      <= 1'b0;
            half_cnt <= '0;
            edges    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else if (!busy) begin
            if (i_TX_DV) begin
                busy     <= 1'b1;
                half_cnt <= '0;
                edges    <= 5'd16;
                tx_sr    <= i_TX_Byte;
            end
        end else if (half_cnt == HW'(CLKS_PER_HALF_BIT - 1)) begin
            half_cnt <= '0;
            sck      <= ~sck;
            edges    <= edges - 5'd1;
            if (!sck) begin
                rx_sr <= {rx_sr[6:0], i_SPI_MISO};
            end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
                if (edges == 5'd1) begin
                    busy    <= 1'b0;
                    o_RX_DV <= 1'b1;
                end
            end
        end else begin
            half_cnt <= half_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/jstk_poller.sv
// Round-robin poller for JSTK2 joysticks on a shared SPI bus.
// JSTK_LED_CMD_EN: send set-LED frames carrying i_led_rgb.
import jstk_pkg::*;

module jstk_poller #(
    parameter int NUM_DEV            = 2,
    parameter int CLKS_PER_HALF_BIT  = 12,
    parameter int SAMPLE_PERIOD_CLKS = 1048576,
    parameter int CS_SETUP_CLKS      = 500,
    parameter int INTERBYTE_CLKS     = 300,
    parameter int CS_HOLD_CLKS       = 800
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_enable,
    input  logic [NUM_DEV*24-1:0] i_led_rgb,
    output logic [NUM_DEV-1:0]    CS_n,
    output logic                  MOSI,
    output logic                  SCK,
    input  logic                  MISO,
    output logic [NUM_DEV*10-1:0] x_pos,
    output logic [NUM_DEV*10-1:0] y_pos,
    output logic [NUM_DEV*8-1:0]  buttons,
    output logic                  o_frame_dv,
    output logic [2:0]            o_frame_dev,
    output logic                  o_busy
);

    localparam int SW = (SAMPLE_PERIOD_CLKS > 1) ?
                        $clog2(SAMPLE_PERIOD_CLKS) : 1;

    state_t      state;
    logic [SW-1:0] smp_cnt;
    logic        tick;
    logic [2:0]  cur_dev;
    logic [2:0]  idx;
    logic [31:0] dly;
    logic [7:0]  shadow [4];
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        rx_dv;
    logic [7:0]  rx_byte;

`ifdef JSTK_LED_CMD_EN
    logic [23:0] rgb;
`else
    wire unused_led = ^i_led_rgb;
`endif

    assign tick   = (smp_cnt == SW'(SAMPLE_PERIOD_CLKS - 1));
    assign o_busy = (state != S_IDLE);

    // Free-running timebase; terminal count is the frame tick.
    always_ff @(posedge CLK) begin
        if (RST || tick)
            smp_cnt <= '0;
        else
            smp_cnt <= smp_cnt + SW'(1);
    end

    // Frame sequencer; a frame's fields land together at CS_n rise.
    always_ff @(posedge CLK) begin
        tx_dv      <= 1'b0;
        o_frame_dv <= 1'b0;
        if (RST) begin
            state       <= S_IDLE;
            cur_dev     <= '0;
            idx         <= '0;
            dly         <= '0;
            CS_n        <= '1;
            x_pos       <= '0;
            y_pos       <= '0;
            buttons     <= '0;
            o_frame_dev <= '0;
            tx_byte     <= '0;
            for (int i = 0; i < 4; i++)
                shadow[i] <= '0;
`ifdef JSTK_LED_CMD_EN
            rgb         <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: if (tick && i_enable) begin
                    CS_n  <= ~(NUM_DEV'(1) << cur_dev);
`ifdef JSTK_LED_CMD_EN
                    rgb   <= i_led_rgb[24*cur_dev +: 24];
`endif
                    idx   <= '0;
                    dly   <= 32'(CS_SETUP_CLKS);
                    state <= S_SETUP;
                end
                S_SETUP, S_GAP: begin
                    if (dly == 32'd0)
                        state <= S_SEND;
                    else
                        dly <= dly - 32'd1;
                end
                S_SEND: if (tx_ready) begin
                    tx_dv <= 1'b1;
`ifdef JSTK_LED_CMD_EN
                    tx_byte <= led_byte(idx, rgb);
`else
                    tx_byte <= CMD_POLL;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: if (rx_dv) begin
                    if (idx == 3'(FRAME_LEN - 1)) begin
                        CS_n <= '1;
                        x_pos[10*cur_dev +: 10] <=
                            {shadow[1][1:0], shadow[0]};
                        y_pos[10*cur_dev +: 10] <=
                            {shadow[3][1:0], shadow[2]};
                        buttons[8*cur_dev +: 8] <= rx_byte;
                        o_frame_dv  <= 1'b1;
                        o_frame_dev <= cur_dev;
                        dly         <= 32'(CS_HOLD_CLKS);
                        state       <= S_HOLD;
                    end else begin
                        shadow[idx[1:0]] <= rx_byte;
                        idx   <= idx + 3'd1;
                        dly   <= 32'(INTERBYTE_CLKS);
                        state <= S_GAP;
                    end
                end
                S_HOLD: begin
                    if (dly == 32'd0) begin
                        cur_dev <= (cur_dev == 3'(NUM_DEV - 1)) ?
                                   3'd0 : cur_dev + 3'd1;
                        state   <= S_IDLE;
                    end else begin
                        dly <= dly - 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    SPI_Master #(
        .SPI_MODE          (0),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_spi (
        .i_Rst_L    (~RST),
        .i_Clk      (CLK),
        .i_TX_Byte  (tx_byte),
        .i_TX_DV    (tx_dv),
        .o_TX_Ready (tx_ready),
        .o_RX_DV    (rx_dv),
        .o_RX_Byte  (rx_byte),
        .o_SPI_Clk  (SCK),
        .i_SPI_MISO (MISO),
        .o_SPI_MOSI (MOSI)
    );

endmodule
